// File: rtl/cursor_readout_pkg.sv
// cursor_readout_pkg: shared FSM/mode types, datapath widths and segment glyphs
package cursor_readout_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_CLAMP, S_BCD, S_LATCH} state_t;
  typedef enum logic [1:0] {M_NONE, M_Y, M_X} mode_t;
  localparam int POS_W = 11;
  localparam int FAC_W = 20;
  localparam int PROD_W = 31;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int MULT_CYC = 20;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_U = 7'h41;
  localparam logic [6:0] SEG_T = 7'h07;
  localparam logic [6:0] SEG_ONE = 7'h79;
  localparam logic [6:0] SEG_TWO = 7'h24;
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < BCD_W / 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/cursor_readout_if.sv
// cursor_readout_if: controls-side inputs and display-side outputs of the readout
interface cursor_readout_if;
  import cursor_readout_pkg::*;
  logic update;
  logic [POS_W-1:0] cursorX1, cursorX2, cursorY1, cursorY2;
  logic cursorX_EN, cursorY_EN;
  logic [1:0] waveSel;
  logic [3:0] shiftDown1, shiftDown2;
  logic [5:0] sampleAdjust1, sampleAdjust2;
  logic busy, done, overflow;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  modport master (
    output update, cursorX1, cursorX2, cursorY1, cursorY2, cursorX_EN, cursorY_EN,
           waveSel, shiftDown1, shiftDown2, sampleAdjust1, sampleAdjust2,
    input  busy, done, overflow, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
  modport slave (
    input  update, cursorX1, cursorX2, cursorY1, cursorY2, cursorX_EN, cursorY_EN,
           waveSel, shiftDown1, shiftDown2, sampleAdjust1, sampleAdjust2,
    output busy, done, overflow, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low 7-segment (bit 0 = seg a), blank on request
module seg7_decode
  import cursor_readout_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank)
      case (digit)
        4'd0: seg = 7'h40;
        4'd1: seg = 7'h79;
        4'd2: seg = 7'h24;
        4'd3: seg = 7'h30;
        4'd4: seg = 7'h19;
        4'd5: seg = 7'h12;
        4'd6: seg = 7'h02;
        4'd7: seg = 7'h78;
        4'd8: seg = 7'h00;
        4'd9: seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/cursor_readout.sv
// cursor_readout: cursor separation -> scaled magnitude -> BCD -> HEX5..HEX0,
// using an iterative shift-add multiply and sequential double-dabble.
module cursor_readout
  import cursor_readout_pkg::*;
#(
  parameter logic [7:0] Y_SCALE_MV = 8'd8,
  parameter logic [7:0] X_SCALE_US = 8'd10,
  parameter int         RES_SHIFT  = 3,
  parameter int         SAT_MAX    = 9999
) (
  input logic clock,
  input logic resetn,
  cursor_readout_if.slave bus
);
  state_t state, state_nxt;
  mode_t mode, mode_sel;
  logic pending, wave2, wave2_sel, sat, over;
  logic [4:0] cnt;
  logic [3:0] sd_raw, sd;
  logic [5:0] sa;
  logic [POS_W-1:0] dx, dy;
  logic [FAC_W-1:0] mplier, factor_y, factor_x;
  logic [PROD_W-1:0] mcand, prod, scaled;
  logic [BIN_W-1:0] bin;
  logic [BCD_W-1:0] bcd, adj, bcd_nxt;
  logic [3:0][6:0] seg;
  logic [5:0][6:0] hex;
  assign wave2_sel = |bus.waveSel;
  assign mode_sel = bus.cursorY_EN ? M_Y : bus.cursorX_EN ? M_X : M_NONE;
  assign dx = bus.cursorX1 >= bus.cursorX2 ? bus.cursorX1 - bus.cursorX2 : bus.cursorX2 - bus.cursorX1;
  assign dy = bus.cursorY1 >= bus.cursorY2 ? bus.cursorY1 - bus.cursorY2 : bus.cursorY2 - bus.cursorY1;
  assign sd_raw = wave2_sel ? bus.shiftDown2 : bus.shiftDown1;
  assign sd = sd_raw > 4'd11 ? 4'd11 : sd_raw;
  assign sa = wave2_sel ? bus.sampleAdjust2 : bus.sampleAdjust1;
  assign factor_y = FAC_W'(Y_SCALE_MV) << sd;
  assign factor_x = FAC_W'(X_SCALE_US) * (FAC_W'(sa) + FAC_W'(1));
  assign scaled = mode == M_Y ? prod >> RES_SHIFT : prod;
  assign over = scaled > PROD_W'(SAT_MAX);
  assign adj = dabble_adj(bcd);
  assign bcd_nxt = {adj[BCD_W-2:0], bin[BIN_W-1]};
  // Digits decode the post-shift BCD so the final dabble step lands directly in HEX
  for (genvar g = 0; g < 4; g++) begin : g_dig
    seg7_decode u_dig (.digit(bcd_nxt[4*g +: 4]), .blank(state != S_BCD), .seg(seg[g]));
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = (bus.update || pending) ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = mode_sel == M_NONE ? S_LATCH : S_MULT;
      S_MULT:  state_nxt = cnt == 5'(MULT_CYC - 1) ? S_CLAMP : S_MULT;
      S_CLAMP: state_nxt = S_BCD;
      S_BCD:   state_nxt = cnt == 5'(BIN_W - 1) ? S_LATCH : S_BCD;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      pending <= 1'b0;
      mode <= M_NONE;
      wave2 <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      bin <= '0;
      bcd <= '0;
      sat <= 1'b0;
      bus.overflow <= 1'b0;
      hex <= {6{SEG_BLANK}};
    end else begin
      pending <= state == S_IDLE ? 1'b0 : pending | bus.update;
      cnt <= state_nxt != state ? '0 : cnt + 5'd1;
      case (state)
        S_LOAD: begin
          mode <= mode_sel;
          wave2 <= wave2_sel;
          mcand <= PROD_W'(mode_sel == M_Y ? dy : dx);
          mplier <= mode_sel == M_Y ? factor_y : factor_x;
          prod <= '0;
        end
        S_MULT: begin
          prod <= mplier[0] ? prod + mcand : prod;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
        end
        S_CLAMP: begin
          bin <= over ? BIN_W'(SAT_MAX) : BIN_W'(scaled);
          sat <= over;
          bcd <= '0;
        end
        S_BCD: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
        end
        default: ;
      endcase
      // Entering LATCH from LOAD means mode NONE: everything blanks
      if (state_nxt == S_LATCH) begin
        hex[3:0] <= seg;
        hex[4] <= state == S_BCD ? (wave2 ? SEG_TWO : SEG_ONE) : SEG_BLANK;
        hex[5] <= state == S_BCD ? (mode == M_Y ? SEG_U : SEG_T) : SEG_BLANK;
        bus.overflow <= state == S_BCD && sat;
      end
    end
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_LATCH;
  assign {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} = hex;
endmodule
